mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 14 +
 rtl/mem_arbiter.sv | 76 +++++++
 2 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state encoding and bus width defaults shared by the
// caches, the arbiter and the data memory.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 256;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter (I-cache = 0, D-cache = 1)
// in front of a single line-wide data memory port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [LINE_W-1:0] m0_data_i,
    output logic [LINE_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [LINE_W-1:0] m1_data_i,
    output logic [LINE_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       r_last;
    logic       w_pick1;
    logic       w_g0;
    logic       w_g1;

    // r_last remembers who won the previous grant; a tie goes to the other one
    assign w_pick1 = m1_enable_i & (~m0_enable_i | ~r_last);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_next != IDLE)
                r_last <= (w_next == GRANT1);
        end
    end

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:    w_next = (m0_enable_i | m1_enable_i) ? (w_pick1 ? GRANT1 : GRANT0) : IDLE;
            GRANT0,
            GRANT1:  w_next = mem_ack_i ? IDLE : r_state;
            default: w_next = IDLE;
        endcase
    end

    assign w_g0 = (r_state == GRANT0);
    assign w_g1 = (r_state == GRANT1);

    assign mem_enable_o = (w_g0 & m0_enable_i) | (w_g1 & m1_enable_i);
    assign mem_write_o  = (w_g0 & m0_enable_i & m0_write_i) | (w_g1 & m1_enable_i & m1_write_i);
    assign mem_addr_o   = w_g0 ? m0_addr_i : (w_g1 ? m1_addr_i : '0);
    assign mem_data_o   = w_g0 ? m0_data_i : (w_g1 ? m1_data_i : '0);
    assign m0_ack_o     = w_g0 & mem_ack_i;
    assign m1_ack_o     = w_g1 & mem_ack_i;

    // Fill data is broadcast to both caches; only reset blanks it
    assign m0_data_o = rst_i ? mem_data_i : '0;
    assign m1_data_o = rst_i ? mem_data_i : '0;

endmodule
